// File: rtl/jump_lut.sv
// Branch-target lookup table: DEPTH labelled PC targets with valid bits, cleared one per cycle
// after reset. Define JUMP_LUT_BYPASS_EN to forward a same-cycle write to a same-label lookup.
module jump_lut #(
    parameter int unsigned LABEL_W = 8,
    parameter int unsigned PC_W    = 12,
    parameter int unsigned DEPTH   = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               init_busy,
    input  logic               wr_en,
    input  logic [LABEL_W-1:0] wr_label,
    input  logic [PC_W-1:0]    wr_pc,
    input  logic               lk_valid,
    input  logic [LABEL_W-1:0] lk_label,
    output logic               lk_ready,
    output logic               rs_valid,
    output logic [PC_W-1:0]    next_pc,
    output logic               hit,
    output logic [15:0]        miss_count
);

    localparam int unsigned IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic {StInit, StRun} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [PC_W-1:0]    tgt_mem [DEPTH];
    logic [DEPTH-1:0]   valid_q;

    logic               rs_valid_q;
    logic [PC_W-1:0]    next_pc_q;
    logic               hit_q;
    logic [15:0]        miss_q;

    logic               wr_in_range, lk_in_range;
    logic [IDX_W-1:0]   wr_idx, lk_idx;
    logic               wr_fire, lk_fire;
    logic               lk_hit_d;
    logic [PC_W-1:0]    lk_pc_d;

    assign wr_in_range = 32'(wr_label) < DEPTH;
    assign lk_in_range = 32'(lk_label) < DEPTH;
    assign wr_idx      = wr_label[IDX_W-1:0];
    assign lk_idx      = lk_label[IDX_W-1:0];

    assign init_busy = (state_q == StInit);
    assign lk_ready  = ~init_busy;
    assign wr_fire   = (state_q == StRun) && wr_en && wr_in_range;
    assign lk_fire   = lk_valid && lk_ready;

    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        if (state_q == StInit) begin
            clr_ptr_d = clr_ptr_q + 1'b1;
            if (clr_ptr_q == IDX_W'(DEPTH - 1)) begin
                state_d   = StRun;
                clr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StInit;
            clr_ptr_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
        end
    end

    // Storage is never reset; INIT sweeps the valid bits instead.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            valid_q[clr_ptr_q] <= 1'b0;
        end else if (wr_fire) begin
            valid_q[wr_idx] <= 1'b1;
            tgt_mem[wr_idx] <= wr_pc;
        end
    end

    always_comb begin
        lk_hit_d = lk_in_range && valid_q[lk_idx];
        lk_pc_d  = lk_hit_d ? tgt_mem[lk_idx] : '0;
`ifdef JUMP_LUT_BYPASS_EN
        if (wr_fire && (wr_label == lk_label)) begin
            lk_hit_d = 1'b1;
            lk_pc_d  = wr_pc;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs_valid_q <= 1'b0;
            next_pc_q  <= '0;
            hit_q      <= 1'b0;
            miss_q     <= '0;
        end else begin
            rs_valid_q <= lk_fire;
            if (lk_fire) begin
                next_pc_q <= lk_pc_d;
                hit_q     <= lk_hit_d;
                if (!lk_hit_d && (miss_q != 16'hFFFF)) begin
                    miss_q <= miss_q + 16'd1;
                end
            end
        end
    end

    assign rs_valid   = rs_valid_q;
    assign next_pc    = next_pc_q;
    assign hit        = hit_q;
    assign miss_count = miss_q;

endmodule

// File: tb/tb_jump_lut.sv
// Self-checking bench for jump_lut: per-cycle comparison against a table-level model,
// plus directed literal checks and randomized traffic.
module tb_jump_lut;

    localparam int unsigned LABEL_W = 8;
    localparam int unsigned PC_W    = 12;
    localparam int unsigned DEPTH   = 64;
`ifdef JUMP_LUT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               init_busy;
    logic               wr_en;
    logic [LABEL_W-1:0] wr_label;
    logic [PC_W-1:0]    wr_pc;
    logic               lk_valid;
    logic [LABEL_W-1:0] lk_label;
    logic               lk_ready;
    logic               rs_valid;
    logic [PC_W-1:0]    next_pc;
    logic               hit;
    logic [15:0]        miss_count;

    jump_lut #(.LABEL_W(LABEL_W), .PC_W(PC_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_busy (init_busy),
        .wr_en     (wr_en),
        .wr_label  (wr_label),
        .wr_pc     (wr_pc),
        .lk_valid  (lk_valid),
        .lk_label  (lk_label),
        .lk_ready  (lk_ready),
        .rs_valid  (rs_valid),
        .next_pc   (next_pc),
        .hit       (hit),
        .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Model: a table of targets indexed by label, plus an INIT countdown.
    logic            m_valid [256];
    logic [PC_W-1:0] m_pc    [256];
    int              m_init_left;
    logic            exp_rs;
    logic [PC_W-1:0] exp_pc;
    logic            exp_hit;
    logic [15:0]     exp_miss;

    int  n_checks = 0;
    int  n_errors = 0;
    bit  chk_on   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_valid[i] = 1'b0;
        m_init_left = DEPTH;
        exp_rs   = 1'b0;
        exp_pc   = '0;
        exp_hit  = 1'b0;
        exp_miss = '0;
    endtask

    task automatic model_edge();
        bit              in_rng;
        bit              h;
        logic [PC_W-1:0] p;
        if (m_init_left > 0) begin
            m_init_left--;
            exp_rs = 1'b0;
        end else begin
            exp_rs = lk_valid;
            if (lk_valid) begin
                in_rng = int'(lk_label) < DEPTH;
                h = in_rng && m_valid[lk_label];
                p = h ? m_pc[lk_label] : '0;
                if (BYP && wr_en && in_rng && (wr_label == lk_label)) begin
                    h = 1'b1;
                    p = wr_pc;
                end
                exp_hit = h;
                exp_pc  = p;
                if (!h && exp_miss != 16'hFFFF) exp_miss++;
            end
            if (wr_en && int'(wr_label) < DEPTH) begin
                m_valid[wr_label] = 1'b1;
                m_pc[wr_label]    = wr_pc;
            end
        end
    endtask

    task automatic drive(input logic we, input int wl, input int wp, input logic lv, input int ll);
        wr_en    = we;
        wr_label = LABEL_W'(wl);
        wr_pc    = PC_W'(wp);
        lk_valid = lv;
        lk_label = LABEL_W'(ll);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("init_busy",  32'(init_busy),  32'(m_init_left > 0));
            check("lk_ready",   32'(lk_ready),   32'(m_init_left == 0));
            check("rs_valid",   32'(rs_valid),   32'(exp_rs));
            check("next_pc",    32'(next_pc),    32'(exp_pc));
            check("hit",        32'(hit),        32'(exp_hit));
            check("miss_count", 32'(miss_count), 32'(exp_miss));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        model_reset();
        chk_on = 1'b1;
        step();
        step();
        check("rst_busy", 32'(init_busy), 32'd1);
        check("rst_next_pc", 32'(next_pc), 32'd0);
        rst_n = 1'b1;

        // INIT length, with traffic that must be ignored
        cnt = 0;
        while (init_busy && cnt < 200) begin
            cnt++;
            drive(1, cnt % 16, cnt, 1, cnt % 16);
            step();
        end
        check("init_cycles", 32'(cnt), 32'd64);
        check("ready_after_init", 32'(lk_ready), 32'd1);

        // Write then look up; miss on neighbour
        drive(1, 5, 323, 0, 0); step();
        drive(0, 0, 0, 1, 5);   step();
        check("l5_rs", 32'(rs_valid), 32'd1);
        check("l5_pc", 32'(next_pc), 32'd323);
        check("l5_hit", 32'(hit), 32'd1);
        drive(0, 0, 0, 0, 0);   step();
        check("hold_rs", 32'(rs_valid), 32'd0);
        check("hold_pc", 32'(next_pc), 32'd323);
        drive(0, 0, 0, 1, 6);   step();
        check("l6_pc", 32'(next_pc), 32'd0);
        check("l6_hit", 32'(hit), 32'd0);
        check("l6_miss", 32'(miss_count), 32'd1);

        // Out-of-range write is dropped and must not alias label 200 % 64 = 8
        drive(1, 200, 7, 1, 200); step();
        check("l200_hit", 32'(hit), 32'd0);
        check("l200_pc", 32'(next_pc), 32'd0);
        drive(0, 0, 0, 1, 200); step();
        check("l200b_hit", 32'(hit), 32'd0);
        drive(0, 0, 0, 1, 8); step();
        check("l8_hit", 32'(hit), 32'd0);
        check("l8_miss", 32'(miss_count), 32'd4);

        // Same-cycle write and lookup of label 9
        drive(1, 9, 267, 1, 9); step();
        check("byp_pc", 32'(next_pc), BYP ? 32'd267 : 32'd0);
        check("byp_hit", 32'(hit), 32'(BYP));
        drive(0, 0, 0, 1, 9); step();
        check("l9_pc", 32'(next_pc), 32'd267);
        check("l9_hit", 32'(hit), 32'd1);

        // Reset mid-RUN wipes entries and counter
        drive(1, 3, 201, 0, 0); step();
        drive(0, 0, 0, 0, 0);
        reset_pulse();
        cnt = 0;
        while (init_busy && cnt < 200) begin
            cnt++;
            step();
        end
        check("reinit_cycles", 32'(cnt), 32'd64);
        drive(0, 0, 0, 1, 3); step();
        check("l3_hit", 32'(hit), 32'd0);
        check("l3_miss", 32'(miss_count), 32'd1);

        // Randomized traffic, with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                drive(0, 0, 0, 0, 0);
                reset_pulse();
            end
            drive(($urandom_range(0, 1) == 1), $urandom_range(0, 79), $urandom,
                  ($urandom_range(0, 9) < 6), $urandom_range(0, 79));
            if ($urandom_range(0, 7) == 0) lk_label = wr_label;
            step();
        end

        // Saturation of the miss counter
        drive(0, 0, 0, 1, 200);
        for (int i = 0; i < 70000 && exp_miss != 16'hFFFF; i++) step();
        check("sat_reach", 32'(miss_count), 32'hFFFF);
        step();
        step();
        check("sat_hold", 32'(miss_count), 32'hFFFF);
        drive(0, 0, 0, 0, 0);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
